// File: rtl/pipe_stage_if.sv
// Valid/ready handshake bundle for one pipeline stage: upstream (in_*) and downstream (out_*) sides.
// master = the environment around the stage, slave = the stage itself.
interface pipe_stage_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline register stage with stall/flush control and saturating statistics counters.
// Optional second skid entry (breaks the out_ready -> in_ready path) under `PIPE_STAGE_SKID_EN.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    pipe_stage_if.slave      bus,
    input  logic             stall,
    input  logic             flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    logic              r_main_valid;
    logic [DATA_W-1:0] r_main_data;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic              w_main_valid_nxt;
    logic [DATA_W-1:0] w_main_data_nxt;
    logic [CNT_W-1:0]  w_stall_cnt_nxt;
    logic [CNT_W-1:0]  w_flush_cnt_nxt;
    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_in_xfer;
    logic              w_out_xfer;
    logic              w_any_valid;

`ifdef PIPE_STAGE_SKID_EN
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;
    logic              w_skid_valid_nxt;
    logic [DATA_W-1:0] w_skid_data_nxt;

    // Skid build: acceptance depends only on local state, never on out_ready.
    assign w_in_ready  = !reset && !flush && !stall && !r_skid_valid;
    assign w_any_valid = r_main_valid || r_skid_valid;
`else
    assign w_in_ready  = !reset && !flush && !stall && (!r_main_valid || bus.out_ready);
    assign w_any_valid = r_main_valid;
`endif

    assign w_out_valid   = r_main_valid && !stall;
    assign w_in_xfer     = bus.in_valid && w_in_ready;
    assign w_out_xfer    = w_out_valid && bus.out_ready;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_main_data;
    assign stall_cnt     = r_stall_cnt;
    assign flush_cnt     = r_flush_cnt;

    // Next-state: flush squashes everything, otherwise move payloads and count stalls.
    always_comb begin
        w_main_valid_nxt = r_main_valid;
        w_main_data_nxt  = r_main_data;
        w_stall_cnt_nxt  = r_stall_cnt;
        w_flush_cnt_nxt  = r_flush_cnt;
`ifdef PIPE_STAGE_SKID_EN
        w_skid_valid_nxt = r_skid_valid;
        w_skid_data_nxt  = r_skid_data;
`endif
        if (flush) begin
            w_main_valid_nxt = 1'b0;
            w_main_data_nxt  = {DATA_W{1'b0}};
`ifdef PIPE_STAGE_SKID_EN
            w_skid_valid_nxt = 1'b0;
            w_skid_data_nxt  = {DATA_W{1'b0}};
`endif
            if (w_any_valid) begin
                w_flush_cnt_nxt = sat_inc(r_flush_cnt);
            end else begin
                w_flush_cnt_nxt = r_flush_cnt;
            end
        end else begin
            if (stall) begin
                w_stall_cnt_nxt = sat_inc(r_stall_cnt);
            end else begin
                w_stall_cnt_nxt = r_stall_cnt;
            end
`ifdef PIPE_STAGE_SKID_EN
            // Skid is always older than new input, so it refills main first.
            if (w_out_xfer) begin
                if (r_skid_valid) begin
                    w_main_data_nxt  = r_skid_data;
                    w_skid_valid_nxt = 1'b0;
                end else if (w_in_xfer) begin
                    w_main_data_nxt  = bus.in_data;
                end else begin
                    w_main_valid_nxt = 1'b0;
                end
            end else if (w_in_xfer) begin
                if (r_main_valid) begin
                    w_skid_valid_nxt = 1'b1;
                    w_skid_data_nxt  = bus.in_data;
                end else begin
                    w_main_valid_nxt = 1'b1;
                    w_main_data_nxt  = bus.in_data;
                end
            end else begin
                w_main_valid_nxt = r_main_valid;
            end
`else
            if (w_in_xfer) begin
                w_main_valid_nxt = 1'b1;
                w_main_data_nxt  = bus.in_data;
            end else if (w_out_xfer) begin
                w_main_valid_nxt = 1'b0;
            end else begin
                w_main_valid_nxt = r_main_valid;
            end
`endif
        end
    end

    // State registers with synchronous reset overriding all other activity.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_main_valid <= 1'b0;
            r_main_data  <= {DATA_W{1'b0}};
            r_stall_cnt  <= {CNT_W{1'b0}};
            r_flush_cnt  <= {CNT_W{1'b0}};
`ifdef PIPE_STAGE_SKID_EN
            r_skid_valid <= 1'b0;
            r_skid_data  <= {DATA_W{1'b0}};
`endif
        end else begin
            r_main_valid <= w_main_valid_nxt;
            r_main_data  <= w_main_data_nxt;
            r_stall_cnt  <= w_stall_cnt_nxt;
            r_flush_cnt  <= w_flush_cnt_nxt;
`ifdef PIPE_STAGE_SKID_EN
            r_skid_valid <= w_skid_valid_nxt;
            r_skid_data  <= w_skid_data_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios then random traffic against a FIFO-style model.
// Honours `PIPE_STAGE_SKID_EN (stage capacity 2 instead of 1).
module tb_pipe_stage_reg;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;
`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             clk = 1'b0;
    logic             reset;
    logic             stall;
    logic             flush;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    pipe_stage_if #(.DATA_W(DATA_W)) bus ();

    pipe_stage_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .stall     (stall),
        .flush     (flush),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: ordered list of held payloads plus last visible data word.
    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] m_data;
    int                m_stall_cnt;
    int                m_flush_cnt;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic model_in_ready(input logic rst, input logic stl, input logic fl, input logic ordy);
        if (rst || fl || stl) return 1'b0;
        if (CAP == 2) return (q.size() < 2);
        return (q.size() == 0) || ordy;
    endfunction

    task automatic step(input logic rst, input logic iv, input logic [DATA_W-1:0] d,
                        input logic ordy, input logic stl, input logic fl);
        logic exp_ir, exp_ov, in_x, out_x;
        logic [DATA_W-1:0] pay;
        reset = rst; bus.in_valid = iv; bus.in_data = d;
        bus.out_ready = ordy; stall = stl; flush = fl;
        #1;
        exp_ir = model_in_ready(rst, stl, fl, ordy);
        exp_ov = (q.size() > 0) && !stl;
        check("in_ready",  {31'd0, bus.in_ready},  {31'd0, exp_ir});
        check("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_ov});
        check("out_data",  bus.out_data, m_data);
        check("stall_cnt", {28'd0, stall_cnt}, m_stall_cnt[DATA_W-1:0]);
        check("flush_cnt", {28'd0, flush_cnt}, m_flush_cnt[DATA_W-1:0]);
        in_x  = iv && exp_ir;
        out_x = exp_ov && ordy;
        @(posedge clk);
        if (rst) begin
            q.delete(); m_data = '0; m_stall_cnt = 0; m_flush_cnt = 0;
        end else if (fl) begin
            if (q.size() > 0 && m_flush_cnt < int'(CNT_MAX)) m_flush_cnt++;
            q.delete(); m_data = '0;
        end else begin
            if (stl && m_stall_cnt < int'(CNT_MAX)) m_stall_cnt++;
            if (out_x) pay = q.pop_front();
            if (in_x) q.push_back(d);
            if (q.size() > 0) m_data = q[0];
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 32'hDEADBEEF; bus.out_ready = 1'b0;
        q.delete(); m_data = '0; m_stall_cnt = 0; m_flush_cnt = 0;
        @(posedge clk);
        @(negedge clk);

        // Reset held two cycles with valid input present.
        step(1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
        check("rst_out_data", bus.out_data, 32'h0);

        // Stall with 0x55 held: counts 4, then delivered once.
        step(1'b0, 1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        check("stall_cnt_4", {28'd0, stall_cnt}, 32'd4);
        check("stall_hold_data", bus.out_data, 32'h55);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Flush with 0x66 held and 0x77 offered.
        step(1'b0, 1'b1, 32'h66, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h77, 1'b0, 1'b0, 1'b1);
        check("flush_cnt_1", {28'd0, flush_cnt}, 32'd1);
        check("flush_data0", bus.out_data, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Streaming 1,2,3 back-to-back.
        for (int i = 1; i <= 3; i++) step(1'b0, 1'b1, i[DATA_W-1:0], 1'b1, 1'b0, 1'b0);
        check("stream_last", bus.out_data, 32'h3);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Backpressure: feed 0xA, 0xB with out_ready low, then release.
        step(1'b0, 1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
        check("bp_head", bus.out_data, 32'hA);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Saturation: 20 stall cycles on a 4-bit counter.
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        check("stall_sat", {28'd0, stall_cnt}, 32'd15);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        check("stall_sat_hold", {28'd0, stall_cnt}, 32'd15);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(63) == 0), ($urandom_range(1) == 1), $urandom,
                 ($urandom_range(2) != 0), ($urandom_range(4) == 0), ($urandom_range(15) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The parameter DATA_W SHALL default to 32 and set the width of the stage payload.
REQ-002 The parameter CNT_W SHALL default to 16 and set the width of each statistics counter.
REQ-003 Port clk SHALL be an input, 1 bit wide, and be the single clock; all state updates on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit wide, and be the synchronous, active-high reset.
REQ-005 Port in_valid SHALL be an input, 1 bit wide, and indicate that the upstream payload is valid.
REQ-006 Port in_data SHALL be an input, DATA_W bits wide, and carry the upstream payload.
REQ-007 Port in_ready SHALL be an output, 1 bit wide, and indicate that the stage accepts a payload this cycle.
REQ-008 Port out_valid SHALL be an output, 1 bit wide, and indicate that the stage holds a deliverable payload.
REQ-009 Port out_data SHALL be an output, DATA_W bits wide, and carry the held payload.
REQ-010 Port out_ready SHALL be an input, 1 bit wide, and indicate that downstream accepts the payload this cycle.
REQ-011 Port stall SHALL be an input, 1 bit wide, and freeze the stage (hazard hold).
REQ-012 Port flush SHALL be an input, 1 bit wide, and kill all held payloads (branch or exception squash).
REQ-013 Port stall_cnt SHALL be an output, CNT_W bits wide, and count stall cycles.
REQ-014 Port flush_cnt SHALL be an output, CNT_W bits wide, and count flushes that killed at least one valid entry.

Function
REQ-015 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-016 out_valid SHALL equal main_valid && !stall; while stall=1, no output transfer occurs and out_data holds its value.
REQ-017 With flush=1, in_ready SHALL be 0, and at the next edge all entries SHALL become invalid and out_data SHALL become 0; flush takes priority over stall, input and output.
REQ-018 The latency from an input transfer to out_valid SHALL be 1 cycle when the stage is empty.
REQ-019 On a simultaneous input and output transfer, the main entry SHALL load the new payload with no bubble, giving a throughput of 1 per cycle.
REQ-020 When no transfer or flush occurs, out_data SHALL hold its last value, including after the entry drains (main_valid=0).
REQ-021 stall_cnt SHALL increment by 1 in each cycle with stall=1 && flush=0 and SHALL saturate at 2^CNT_W-1.
REQ-022 flush_cnt SHALL increment in each cycle with flush=1 and at least one valid entry, and SHALL saturate at 2^CNT_W-1.
REQ-023 Payload bits SHALL pass through unmodified; the stage SHALL never reorder, duplicate or drop a payload except on flush.

Reset
REQ-024 While reset=1 at an edge, main_valid, skid_valid, out_data, stall_cnt and flush_cnt SHALL all become 0.
REQ-025 While reset=1, in_ready SHALL be 0, so no input is accepted during reset.
REQ-026 Reset SHALL override flush, stall and any transfer in progress, and the first transfer SHALL be possible in the cycle after reset deasserts.

Configuration
REQ-027 Macro PIPE_STAGE_SKID_EN SHALL compile in a second skid entry.
REQ-028 Without PIPE_STAGE_SKID_EN, in_ready SHALL be !reset && !flush && !stall && (!main_valid || out_ready), which is combinational from out_ready.
REQ-029 With PIPE_STAGE_SKID_EN, in_ready SHALL be !reset && !flush && !stall && !skid_valid, with no combinational path from out_ready.
REQ-030 With PIPE_STAGE_SKID_EN, an input accepted while main is full and not draining SHALL go to the skid entry.
REQ-031 With PIPE_STAGE_SKID_EN, when main drains, main SHALL load from skid before taking new input, so skid contents are always older than any new input.
REQ-032 With PIPE_STAGE_SKID_EN, sustained throughput SHALL remain 1 per cycle.

Verification
REQ-033 Reset scenario: hold reset for 2 cycles with in_valid=1 and in_data=0xDEADBEEF -> in_ready=0, out_valid=0, out_data=0, and both counters 0.
REQ-034 Streaming scenario: drive out_ready=1 and feed 0x1, 0x2, 0x3 back-to-back -> out_data shows 0x1, 0x2, 0x3 on consecutive cycles with one-cycle latency and no bubbles.
REQ-035 Backpressure scenario: hold out_ready=0 for 3 cycles while feeding 0xA, 0xB -> without skid, 0xA is held and in_ready=0; with skid, 0xB is captured in skid and in_ready drops; on release, 0xA then 0xB are delivered in order.
REQ-036 Stall scenario: assert stall for 4 cycles with 0x55 held -> out_valid=0, out_data=0x55 and stall_cnt=4; after release, 0x55 is delivered once.
REQ-037 Flush scenario: assert flush together with in_valid=1 (in_data=0x77) while 0x66 is held -> next cycle out_valid=0, out_data=0 and flush_cnt=1, and 0x77 is never delivered.
REQ-038 Saturation scenario: with CNT_W=4, hold stall for 20 cycles -> stall_cnt reaches 15 and stays at 15.
